// File: rtl/psum_collector_pkg.sv
// Shared constants, FSM state type and the lane unpack/extend helper for the
// psum_collector block.
package psum_collector_pkg;

   localparam int ACC_W   = 32;
   localparam int LANE_W  = 13;
   localparam int PSUM_W  = 52;
   localparam int N_LANES = 4;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Extended operand for lane idx. In single mode only lane 0 is fed, and the
   // extension bits sit above ACC_W, so truncation makes signedness irrelevant.
   function automatic logic [ACC_W-1:0] lane_extract(
      input int                idx,
      input logic              quad,
      input logic              sgn,
      input logic [PSUM_W-1:0] psum
   );
      logic [LANE_W-1:0] lane;
      logic [ACC_W-1:0]  res;
      lane = psum[LANE_W*idx +: LANE_W];
      if (quad) begin
         if (sgn) begin
            res = {{(ACC_W-LANE_W){lane[LANE_W-1]}}, lane};
         end else begin
            res = {{(ACC_W-LANE_W){1'b0}}, lane};
         end
      end else if (idx == 0) begin
         res = psum[ACC_W-1:0];
      end else begin
         res = {ACC_W{1'b0}};
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Configuration, psum input stream and result output of the psum_collector.
interface psum_collector_if;
   import psum_collector_pkg::*;

   logic                   cfg_start;
   logic [CNT_W-1:0]       cfg_len;
   logic                   cfg_quad;
   logic                   cfg_signed;
   logic                   psum_valid;
   logic [PSUM_W-1:0]      psum_in;
   logic                   psum_ready;
   logic                   out_valid;
   logic [N_LANES*ACC_W-1:0] out_data;
   logic                   out_ready;
   logic                   busy;
   logic                   done;

   modport master (
      output cfg_start, cfg_len, cfg_quad, cfg_signed, psum_valid, psum_in, out_ready,
      input  psum_ready, out_valid, out_data, busy, done
   );

   modport slave (
      input  cfg_start, cfg_len, cfg_quad, cfg_signed, psum_valid, psum_in, out_ready,
      output psum_ready, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/psum_collector_lane_acc.sv
// One wrapping lane accumulator with synchronous clear and add-enable.
module psum_lane_acc
   import psum_collector_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [ACC_W-1:0] operand_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   // Next accumulator value: clear wins over add; sum wraps modulo 2^ACC_W.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = {ACC_W{1'b0}};
      end else if (en_i) begin
         acc_d = acc_q + operand_i;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= {ACC_W{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/psum_collector.sv
// Collects psum beats from a fusion_unit column into four lane accumulators and
// presents the finished result on a valid/ready port.
module psum_collector
   import psum_collector_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   psum_collector_if.slave bus
);

   state_e           state_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cnt_q;
   logic             quad_q;
   logic             signed_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             done_q;

   logic             start_s;
   logic             xfer_s;
   logic [ACC_W-1:0] acc_s [N_LANES];

   assign start_s = (state_q == IDLE) && bus.cfg_start;
   assign xfer_s  = (state_q == ACCUM) && bus.psum_valid;

   // Job FSM, beat counter, latched config and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= {CNT_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         quad_q      <= 1'b0;
         signed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.cfg_start) begin
                  len_q    <= bus.cfg_len;
                  quad_q   <= bus.cfg_quad;
                  signed_q <= bus.cfg_signed;
                  cnt_q    <= {CNT_W{1'b0}};
                  busy_q   <= 1'b1;
                  if (bus.cfg_len == {CNT_W{1'b0}}) begin
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q     <= ACCUM;
                     out_valid_q <= 1'b0;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            ACCUM: begin
               if (bus.psum_valid) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == len_q - CNT_W'(1)) begin
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= ACCUM;
                  end
               end else begin
                  state_q <= ACCUM;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  state_q <= HOLD;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      psum_lane_acc u_acc (
         .clk       (clk),
         .rst       (rst),
         .clr_i     (start_s),
         .en_i      (xfer_s),
         .operand_i (lane_extract(k, quad_q, signed_q, bus.psum_in)),
         .acc_o     (acc_s[k])
      );
      assign bus.out_data[ACC_W*k +: ACC_W] = acc_s[k];
   end

   assign bus.psum_ready = (state_q == ACCUM);
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the bottom of a fusion_unit column and consumes the 52-bit psum_fwd stream.
- Unpacks each beat into lanes according to the precision mode: one wide value, or four 13-bit lanes.
- Sign- or zero-extends each lane and accumulates it over a programmed number of beats.
- Presents the finished accumulators on a valid/ready output port for writeback.

Parameters:
- ACC_W, 32, width of each lane accumulator and output lane.
- LANE_W, 13, width of one packed psum lane in quad mode (4*LANE_W = PSUM_W).
- PSUM_W, 52, width of the incoming psum bus.
- CNT_W, 16, width of the beat counter and cfg_len.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  one-cycle pulse; starts a job. Honoured only in IDLE.
- cfg_len  input  CNT_W  number of psum beats to accumulate; latched on cfg_start.
- cfg_quad  input  1  0 = single 52-bit value, 1 = four LANE_W lanes; latched on cfg_start.
- cfg_signed  input  1  1 = sign-extend lanes, 0 = zero-extend; latched on cfg_start.
- psum_valid  input  1  psum_in beat is valid.
- psum_in  input  PSUM_W  packed psum from fusion_unit psum_fwd; lane k = bits [13k+12:13k].
- psum_ready  output  1  collector accepts a beat this cycle.
- out_valid  output  1  out_data holds a completed result.
- out_data  output  4*ACC_W  lane k at [ACC_W*k+ACC_W-1 : ACC_W*k].
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in ACCUM or HOLD.
- done  output  1  one-cycle pulse on the cycle after the output handshake.

Behaviour:
- Reset values: psum_ready=0, out_valid=0, out_data=0, busy=0, done=0, all accumulators 0, beat count 0, state IDLE.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, on cfg_start:
  - latch cfg_len, cfg_quad and cfg_signed;
  - clear the accumulators and the beat count;
  - go to ACCUM, or straight to HOLD with all-zero accumulators if cfg_len==0.
- ACCUM:
  - psum_ready=1, driven combinationally from state;
  - a beat transfers when psum_valid & psum_ready; the accumulators update on that edge;
  - when the beat count reaches cfg_len-1 on a transfer, the next state is HOLD;
  - cycles with psum_valid low are bubbles and change no state.
- HOLD:
  - psum_ready=0, out_valid=1, out_data = accumulators, held stable while out_ready is low;
  - on out_valid & out_ready, go to IDLE and pulse done on the next cycle.
- Latency: out_valid rises the cycle after the last accepted beat. The IDLE-to-ACCUM turnaround is 1 cycle.
- Quad mode: lane k += ext(psum_in[13k+12:13k]). ext is sign extension from bit 12 when cfg_signed, otherwise zero extension, to ACC_W.
- Single mode:
  - lane0 += psum_in taken as PSUM_W bits, sign- or zero-extended per cfg_signed, then truncated to the low ACC_W bits;
  - lanes 1-3 remain 0.
- Arithmetic: all accumulators wrap modulo 2^ACC_W. No saturation, no overflow flag.
- cfg_start in ACCUM or HOLD is ignored; the latched config is unaffected.
- Changes to the cfg_* inputs after cfg_start have no effect.
- psum_valid asserted in IDLE or HOLD is not accepted (psum_ready=0) and has no effect.
- rst asserted mid-job returns to the reset values on the next edge, and any partial sums are discarded.
- out_data outside HOLD shows the live accumulators and is don't-care to consumers.

Decomposition:
- Shared package holds:
  - PSUM_W=52, LANE_W=13, N_LANES=4;
  - the state enum {IDLE, ACCUM, HOLD};
  - the lane-extract function (index, quad, signed → ACC_W value).
- One sub-module, psum_lane_acc: a single ACC_W accumulator with clear, enable and an extended operand input, instantiated N_LANES times.
- The FSM and beat counter live in the top module.

Test Plan:
- Quad unsigned:
  - stimulus: cfg_len=3, three back-to-back beats of lanes {0,6,12,18};
  - response: out_valid the cycle after beat 3; lanes {0,18,36,54}; done pulses after out_ready.
- Quad signed:
  - stimulus: cfg_len=2, every lane 13'h1FFF on each beat;
  - response: every lane 32'hFFFFFFFE; repeating with cfg_signed=0 gives 32'h00003FFE.
- Single mode:
  - stimulus: cfg_quad=0, cfg_len=2, beats 52'h0FF01 then 52'h0FF01 with 3 psum_valid-low bubbles between them;
  - response: lane0=130562, lanes 1-3 = 0; exactly 2 beats accepted.
- Backpressure:
  - stimulus: out_ready held low for 5 cycles in HOLD, with a cfg_start pulse and psum_valid=1 during that time;
  - response: out_data stable, psum_ready=0, no new job starts; handshake on cycle 6 returns to IDLE.
- Boundaries:
  - cfg_len=0 → HOLD the next cycle with all-zero lanes;
  - unsigned quad with lane0 accumulator at 32'hFFFFFFF0, adding 13'h0020 → wraps to 32'h00000010.
- Reset:
  - stimulus: rst asserted after 2 of 4 beats;
  - response: next edge all outputs 0, busy=0; a new job with cfg_len=1 and lanes {1,2,3,4} yields exactly {1,2,3,4}.
